// File: rtl/ahb_master_burst_ctrl_if.sv
// Command, write-data and AHB beat signals between the burst sequencer and its neighbours.
// master: the sequencer itself; slave: whatever drives commands and consumes the beat stream.
interface ahb_master_burst_ctrl_if #(
  parameter int WDT = 32
);
  logic           i_hready;
  logic           i_hgrant;
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic           i_cmd_write;
  logic [31:0]    i_cmd_addr;
  logic [7:0]     i_cmd_len;
  logic [3:0]     i_cmd_prot;
  logic           i_cmd_lock;
  logic [WDT-1:0] i_wr_data;
  logic           i_wr_dav;
  logic           o_wr_rd;
  logic           o_hwrite;
  logic [WDT-1:0] o_hwdata;
  logic [31:0]    o_haddr;
  logic [1:0]     o_htrans;
  logic [1:0]     o_hburst;
  logic [1:0]     o_hsize;
  logic [3:0]     o_hprot;
  logic           o_hlock;
  logic           o_hbusreq;

  modport master (
    input  i_hready, i_hgrant, i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
           i_cmd_prot, i_cmd_lock, i_wr_data, i_wr_dav,
    output o_cmd_ready, o_wr_rd, o_hwrite, o_hwdata, o_haddr, o_htrans, o_hburst,
           o_hsize, o_hprot, o_hlock, o_hbusreq
  );

  modport slave (
    output i_hready, i_hgrant, i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_len,
           i_cmd_prot, i_cmd_lock, i_wr_data, i_wr_dav,
    input  o_cmd_ready, o_wr_rd, o_hwrite, o_hwdata, o_haddr, o_htrans, o_hburst,
           o_hsize, o_hprot, o_hlock, o_hbusreq
  );
endinterface

// File: rtl/ahb_master_burst_ctrl.sv
// Turns one read/write command into a registered SINGLE/INCR AHB beat stream; beats advance only on hready & hgrant.
// Write underrun inserts BUSY; 1KB crossings and grant loss restart the burst with NONSEQ.
module ahb_master_burst_ctrl #(
  parameter int WDT = 32
) (
  input logic                 i_hclk,
  input logic                 i_hreset_n,
  ahb_master_burst_ctrl_if.master bus
);

  localparam int          INC   = WDT / 8;
  localparam logic [31:0] AMASK = ~(32'(INC) - 32'd1);
  localparam logic [1:0]  HSIZE = (WDT == 64) ? 2'd3 : 2'd2;

  localparam logic [1:0] TR_IDLE = 2'd0;
  localparam logic [1:0] TR_BUSY = 2'd1;
  localparam logic [1:0] TR_NSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ  = 2'd3;
  localparam logic [1:0] BU_SINGLE = 2'd0;
  localparam logic [1:0] BU_INCR   = 2'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_XFER, ST_LAST} state_t;

  state_t      state;
  logic        write_q;
  logic        single_q;
  logic [31:0] addr_q;   // address of the next beat still to be loaded
  logic [8:0]  rem_q;    // beats not yet loaded
  logic        adv;
  logic        beat_go;

  assign adv     = bus.i_hready & bus.i_hgrant;
  assign beat_go = adv & ((state == ST_ARB) | (state == ST_XFER)) & (~write_q | bus.i_wr_dav);

  assign bus.o_wr_rd = beat_go & write_q;
  assign bus.o_hsize = HSIZE;

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state           <= ST_IDLE;
      write_q         <= 1'b0;
      single_q        <= 1'b0;
      addr_q          <= 32'd0;
      rem_q           <= 9'd0;
      bus.o_cmd_ready <= 1'b1;
      bus.o_htrans    <= TR_IDLE;
      bus.o_hwrite    <= 1'b1;
      bus.o_hwdata    <= '0;
      bus.o_haddr     <= 32'd0;
      bus.o_hburst    <= BU_SINGLE;
      bus.o_hprot     <= 4'd0;
      bus.o_hlock     <= 1'b0;
      bus.o_hbusreq   <= 1'b0;
    end else begin
      // Lost grant with a SEQ on the bus: re-present it as the start of a fresh INCR burst.
      if (bus.i_hready && !bus.i_hgrant && bus.o_htrans == TR_SEQ) begin
        bus.o_htrans <= TR_NSEQ;
        bus.o_hburst <= BU_INCR;
      end

      case (state)
        ST_IDLE: begin
          if (bus.i_cmd_valid && bus.o_cmd_ready) begin
            write_q         <= bus.i_cmd_write;
            single_q        <= (bus.i_cmd_len == 8'd0);
            addr_q          <= bus.i_cmd_addr & AMASK;
            rem_q           <= 9'(bus.i_cmd_len) + 9'd1;
            bus.o_cmd_ready <= 1'b0;
            bus.o_hprot     <= bus.i_cmd_prot;
            bus.o_hlock     <= bus.i_cmd_lock;
            bus.o_hbusreq   <= 1'b1;
            state           <= ST_ARB;
          end else begin
            bus.o_cmd_ready <= 1'b1;
          end
        end

        ST_ARB, ST_XFER: begin
          if (beat_go) begin
            bus.o_htrans <= (state == ST_ARB || addr_q[9:0] == 10'd0) ? TR_NSEQ : TR_SEQ;
            if (state == ST_ARB) begin
              bus.o_hburst <= single_q ? BU_SINGLE : BU_INCR;
            end
            bus.o_haddr  <= addr_q;
            bus.o_hwrite <= write_q;
            if (write_q) begin
              bus.o_hwdata <= bus.i_wr_data;
            end
            addr_q <= addr_q + 32'(INC);
            rem_q  <= rem_q - 9'd1;
            if (rem_q == 9'd1) begin
              bus.o_hbusreq <= 1'b0;
              bus.o_hlock   <= 1'b0;
              state         <= ST_LAST;
            end else begin
              state <= ST_XFER;
            end
          end else if (adv) begin
            // Write data not ready: idle before the first beat, BUSY inside the burst.
            if (state == ST_ARB) begin
              bus.o_htrans <= TR_IDLE;
            end else begin
              bus.o_htrans <= TR_BUSY;
              bus.o_haddr  <= addr_q;
            end
          end
        end

        ST_LAST: begin
          if (adv) begin
            bus.o_htrans <= TR_IDLE;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_burst_ctrl.sv
// Directed bench for ahb_master_burst_ctrl: beat-index reference model compared every cycle,
// plus literal beat sequences for each directed scenario.
module tb_ahb_master_burst_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb_master_burst_ctrl_if #(.WDT(32)) bus ();

  ahb_master_burst_ctrl #(.WDT(32)) dut (
    .i_hclk     (clk),
    .i_hreset_n (rst_n),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: beat index k out of n, address = base + 4k ----------------
  int          m_phase;   // 0 idle, 1 waiting first beat, 2 mid burst, 3 last beat on bus
  logic        m_write;
  logic [31:0] m_base;
  int          m_n, m_k;
  logic [1:0]  e_htrans, e_hburst;
  logic [31:0] e_haddr, e_hwdata;
  logic        e_hwrite, e_busreq, e_lock, e_cmd_ready;
  logic [3:0]  e_prot;

  initial forever begin
    logic        adv;
    logic [31:0] a;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_write = 0; m_base = 0; m_n = 0; m_k = 0;
      e_htrans = 2'd0; e_hburst = 2'd0; e_haddr = 0; e_hwdata = 0;
      e_hwrite = 1; e_busreq = 0; e_lock = 0; e_cmd_ready = 1; e_prot = 0;
    end else begin
      adv = bus.i_hready && bus.i_hgrant;
      a   = m_base + 32'(m_k) * 32'd4;
      if (!adv && bus.i_hready && e_htrans == 2'd3) begin
        e_htrans = 2'd2;
        e_hburst = 2'd1;
      end
      case (m_phase)
        0: begin
          if (e_cmd_ready && bus.i_cmd_valid) begin
            m_write = bus.i_cmd_write;
            m_base  = {bus.i_cmd_addr[31:2], 2'b00};
            m_n     = int'(bus.i_cmd_len) + 1;
            m_k     = 0;
            e_busreq = 1; e_lock = bus.i_cmd_lock; e_prot = bus.i_cmd_prot;
            e_cmd_ready = 0;
            m_phase = 1;
          end else begin
            e_cmd_ready = 1;
          end
        end
        1, 2: begin
          if (adv) begin
            if (m_write && !bus.i_wr_dav) begin
              if (m_phase == 2) begin e_htrans = 2'd1; e_haddr = a; end
              else e_htrans = 2'd0;
            end else begin
              e_htrans = (m_k == 0 || a[9:0] == 10'd0) ? 2'd2 : 2'd3;
              if (m_k == 0) e_hburst = (m_n == 1) ? 2'd0 : 2'd1;
              e_haddr  = a;
              e_hwrite = m_write;
              if (m_write) e_hwdata = bus.i_wr_data;
              m_k++;
              if (m_k == m_n) begin
                e_busreq = 0; e_lock = 0; m_phase = 3;
              end else begin
                m_phase = 2;
              end
            end
          end
        end
        default: begin
          if (adv) begin e_htrans = 2'd0; m_phase = 0; end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare and beat log ----------------
  typedef struct {
    logic [1:0]  tr;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [1:0]  hb;
    logic        hw;
    logic        br;
    int          cyc;
  } beat_t;

  beat_t log_q[$];
  int    cyc = 0;
  int    n_wr = 0;
  int    n_busreq = 0;
  int    rdy_cyc = 0;
  logic  prev_rdy = 1'b1;

  initial forever begin
    logic exp_wr_rd;
    @(negedge clk);
    cyc++;
    exp_wr_rd = bus.i_hready && bus.i_hgrant && m_write && bus.i_wr_dav && (m_phase == 1 || m_phase == 2);
    chk("htrans",    32'(bus.o_htrans),    32'(e_htrans));
    chk("haddr",     bus.o_haddr,          e_haddr);
    chk("hburst",    32'(bus.o_hburst),    32'(e_hburst));
    chk("hwrite",    32'(bus.o_hwrite),    32'(e_hwrite));
    chk("hwdata",    bus.o_hwdata,         e_hwdata);
    chk("hsize",     32'(bus.o_hsize),     32'd2);
    chk("hprot",     32'(bus.o_hprot),     32'(e_prot));
    chk("hlock",     32'(bus.o_hlock),     32'(e_lock));
    chk("hbusreq",   32'(bus.o_hbusreq),   32'(e_busreq));
    chk("cmd_ready", 32'(bus.o_cmd_ready), 32'(e_cmd_ready));
    chk("wr_rd",     32'(bus.o_wr_rd),     32'(exp_wr_rd));
    if (rst_n && bus.i_hready && bus.i_hgrant && bus.o_htrans != 2'd0)
      log_q.push_back('{bus.o_htrans, bus.o_haddr, bus.o_hwdata, bus.o_hburst,
                        bus.o_hwrite, bus.o_hbusreq, cyc});
    if (bus.o_wr_rd) n_wr++;
    if (bus.o_hbusreq) n_busreq++;
    if (bus.o_cmd_ready && !prev_rdy) rdy_cyc = cyc;
    prev_rdy = bus.o_cmd_ready;
  end

  // ---------------- show-ahead write data source ----------------
  int widx = 0;
  initial forever begin
    logic fire;
    @(negedge clk);
    fire = bus.o_wr_rd;
    @(posedge clk);
    #1;
    if (fire) widx++;
    bus.i_wr_data = 32'hDA7A_0000 + 32'(widx);
  end

  // ---------------- stimulus ----------------
  // kind: 0 none, 1 wr_dav low, 2 hready low, 3 hgrant low, 4 reset pulse
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [7:0] l,
                         input logic lk, input int kind, input int pc, input int plen);
    logic        got;
    logic        done;
    logic [1:0]  s_tr, s_hb;
    logic [31:0] s_ad, s_wd;
    logic        s_br;
    widx = 0;
    log_q.delete();
    n_wr = 0;
    n_busreq = 0;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1; bus.i_cmd_write = w; bus.i_cmd_addr = a; bus.i_cmd_len = l;
    bus.i_cmd_prot = 4'hA; bus.i_cmd_lock = lk; bus.i_wr_dav = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_cmd_ready) begin got = 1; break; end
    end
    chk("cmd_accepted", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.i_cmd_valid = 0;
    done = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (kind == 2 && c > pc && c <= pc + plen) begin
        chk("freeze_htrans",  32'(bus.o_htrans),  32'(s_tr));
        chk("freeze_haddr",   bus.o_haddr,        s_ad);
        chk("freeze_hburst",  32'(bus.o_hburst),  32'(s_hb));
        chk("freeze_hwdata",  bus.o_hwdata,       s_wd);
        chk("freeze_busreq",  32'(bus.o_hbusreq), 32'(s_br));
      end
      if (kind == 3 && c == pc + 1) begin
        chk("gloss_htrans",  32'(bus.o_htrans),  32'd2);
        chk("gloss_hburst",  32'(bus.o_hburst),  32'd1);
        chk("gloss_haddr",   bus.o_haddr,        32'h208);
        chk("gloss_busreq",  32'(bus.o_hbusreq), 32'd1);
      end
      if (c == pc && kind != 0) begin
        s_tr = bus.o_htrans; s_ad = bus.o_haddr; s_hb = bus.o_hburst;
        s_wd = bus.o_hwdata; s_br = bus.o_hbusreq;
        case (kind)
          1: bus.i_wr_dav = 0;
          2: bus.i_hready = 0;
          3: bus.i_hgrant = 0;
          default: begin
            rst_n = 0;
            #1;
            chk("rst_htrans",    32'(bus.o_htrans),    32'd0);
            chk("rst_hwrite",    32'(bus.o_hwrite),    32'd1);
            chk("rst_hbusreq",   32'(bus.o_hbusreq),   32'd0);
            chk("rst_hlock",     32'(bus.o_hlock),     32'd0);
            chk("rst_haddr",     bus.o_haddr,          32'd0);
            chk("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
          end
        endcase
      end
      if (c == pc + plen && kind != 0) begin
        case (kind)
          1: bus.i_wr_dav = 1;
          2: bus.i_hready = 1;
          3: bus.i_hgrant = 1;
          default: rst_n = 1;
        endcase
      end
      if (c > pc + plen && bus.o_cmd_ready) begin done = 1; break; end
    end
    chk("cmd_completed", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_beat(input int i, input logic [1:0] tr, input logic [31:0] ad);
    if (i >= log_q.size()) begin
      chk($sformatf("beat%0d_present", i), 32'd0, 32'd1);
    end else begin
      chk($sformatf("beat%0d_htrans", i), 32'(log_q[i].tr), 32'(tr));
      chk($sformatf("beat%0d_haddr", i),  log_q[i].ad,      ad);
    end
  endtask

  initial begin : stim
    bus.i_hready = 1; bus.i_hgrant = 1; bus.i_cmd_valid = 0; bus.i_cmd_write = 0;
    bus.i_cmd_addr = 0; bus.i_cmd_len = 0; bus.i_cmd_prot = 0; bus.i_cmd_lock = 0;
    bus.i_wr_dav = 0; bus.i_wr_data = 32'hDA7A_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
    chk("reset_htrans",    32'(bus.o_htrans),    32'd0);
    chk("reset_hwrite",    32'(bus.o_hwrite),    32'd1);
    chk("reset_hsize",     32'(bus.o_hsize),     32'd2);
    chk("reset_hbusreq",   32'(bus.o_hbusreq),   32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // single read
    run_cmd(0, 32'h100, 8'd0, 0, 0, 0, 0);
    chk("t1_beats", 32'(log_q.size()), 32'd1);
    chk_beat(0, 2'd2, 32'h100);
    if (log_q.size() > 0) begin
      chk("t1_hburst", 32'(log_q[0].hb), 32'd0);
      chk("t1_hwrite", 32'(log_q[0].hw), 32'd0);
      chk("t1_rdy_delay", 32'(rdy_cyc - log_q[0].cyc), 32'd2);
    end
    chk("t1_busreq_cycles", 32'(n_busreq), 32'd1);

    // 4-beat locked write
    run_cmd(1, 32'h200, 8'd3, 1, 0, 0, 0);
    chk("t2_beats", 32'(log_q.size()), 32'd4);
    chk_beat(0, 2'd2, 32'h200);
    chk_beat(1, 2'd3, 32'h204);
    chk_beat(2, 2'd3, 32'h208);
    chk_beat(3, 2'd3, 32'h20C);
    for (int i = 0; i < log_q.size(); i++) begin
      chk($sformatf("t2_hwdata%0d", i), log_q[i].wd, 32'hDA7A_0000 + 32'(i));
      chk($sformatf("t2_hburst%0d", i), 32'(log_q[i].hb), 32'd1);
    end
    if (log_q.size() == 4) begin
      chk("t2_busreq_beat2", 32'(log_q[2].br), 32'd1);
      chk("t2_busreq_beat3", 32'(log_q[3].br), 32'd0);
    end
    chk("t2_wr_rd_pulses", 32'(n_wr), 32'd4);

    // 1KB crossing
    run_cmd(0, 32'h3F8, 8'd3, 0, 0, 0, 0);
    chk("t3_beats", 32'(log_q.size()), 32'd4);
    chk_beat(0, 2'd2, 32'h3F8);
    chk_beat(1, 2'd3, 32'h3FC);
    chk_beat(2, 2'd2, 32'h400);
    chk_beat(3, 2'd3, 32'h404);

    // write underrun -> BUSY
    run_cmd(1, 32'h200, 8'd2, 0, 1, 1, 2);
    chk("t4_beats", 32'(log_q.size()), 32'd5);
    chk_beat(0, 2'd2, 32'h200);
    chk_beat(1, 2'd1, 32'h204);
    chk_beat(2, 2'd1, 32'h204);
    chk_beat(3, 2'd3, 32'h204);
    chk_beat(4, 2'd3, 32'h208);
    chk("t4_wr_rd_pulses", 32'(n_wr), 32'd3);

    // hready stall mid burst
    run_cmd(0, 32'h500, 8'd3, 0, 2, 1, 3);
    chk("t5_beats", 32'(log_q.size()), 32'd4);
    chk_beat(0, 2'd2, 32'h500);
    chk_beat(3, 2'd3, 32'h50C);

    // grant loss while SEQ 0x208 presented
    run_cmd(1, 32'h200, 8'd3, 0, 3, 3, 2);
    chk("t6_beats", 32'(log_q.size()), 32'd4);
    chk_beat(0, 2'd2, 32'h200);
    chk_beat(1, 2'd3, 32'h204);
    chk_beat(2, 2'd2, 32'h208);
    chk_beat(3, 2'd3, 32'h20C);
    chk("t6_wr_rd_pulses", 32'(n_wr), 32'd4);

    // reset mid burst, then a fresh command
    run_cmd(1, 32'h600, 8'd7, 1, 4, 2, 2);
    chk("t7_cmd_ready_after_reset", 32'(bus.o_cmd_ready), 32'd1);
    run_cmd(0, 32'h702, 8'd1, 0, 0, 0, 0);
    chk("t7_beats", 32'(log_q.size()), 32'd2);
    chk_beat(0, 2'd2, 32'h700);
    chk_beat(1, 2'd3, 32'h704);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahb_master_burst_ctrl.md
Name: ahb_master_burst_ctrl

Overview:
- Upstream command sequencer for the AHB master pipeline: turns one user command (read/write, start address, beat count) into the per-cycle AHB control/address/write-data beat stream feeding the address-generation stage.
- Generates SINGLE/INCR bursts, inserts BUSY on write-data underrun, restarts with NONSEQ at 1KB boundaries and after grant loss.
- Drives the bus request and lock.

Parameters:
- WDT, 32, data bus width; legal values 32 or 64. Sets address increment (4 or 8) and hsize (2'd2 or 2'd3).

Ports:
- i_hclk  in  1  clock
- i_hreset_n  in  1  reset, asynchronous, active-low
- i_hready  in  1  AHB ready
- i_hgrant  in  1  AHB grant
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  command accept
- i_cmd_write  in  1  1=write, 0=read
- i_cmd_addr  in  32  start byte address
- i_cmd_len  in  8  beats minus one (1..256 beats)
- i_cmd_prot  in  4  hprot for whole command
- i_cmd_lock  in  1  locked command
- i_wr_data  in  WDT  show-ahead write data
- i_wr_dav  in  1  write data available
- o_wr_rd  out  1  write data consumed this edge
- o_hwrite  out  1  to pipeline i_hwrite
- o_hwdata  out  WDT  to pipeline i_hwdata
- o_haddr  out  32  to pipeline i_haddr
- o_htrans  out  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- o_hburst  out  2  0 SINGLE, 1 INCR
- o_hsize  out  2  2'd2 (WDT=32) or 2'd3 (WDT=64)
- o_hprot  out  4  latched prot
- o_hlock  out  1  latched lock
- o_hbusreq  out  1  bus request

Behaviour:
- adv = i_hready & i_hgrant. All beat outputs are registered and load a new beat only on adv; otherwise they hold. Exception: grant-loss rewrite (below).
- Reset values:
  - o_htrans=IDLE, o_hwrite=1, all other outputs 0.
  - o_hsize reset = its WDT constant.
  - State IDLE, o_cmd_ready=1.
  - Reset mid-command aborts the command; no resume.
- States:
  - IDLE: o_cmd_ready=1. Accepts on i_cmd_valid & o_cmd_ready. Latches write/prot/lock. Address is aligned by forcing low log2(WDT/8) bits to 0. Remaining = len+1. Next edge: o_hbusreq=1, o_hlock=lock, state ARB.
  - ARB: wait for adv.
    - Read, or write with i_wr_dav: load first beat NONSEQ; hburst = SINGLE if len==0, else INCR. Go to XFER.
    - Write without i_wr_dav: load IDLE and stay in ARB.
  - XFER: on each adv, load the next beat at addr+WDT/8.
    - htrans=SEQ, or NONSEQ if the new address has addr[9:0]==0 (1KB crossing).
    - Write with !i_wr_dav: load BUSY with the next beat's address; counter unchanged.
  - Last beat loaded: o_hbusreq and o_hlock cleared in the same edge; state LAST.
  - LAST: on adv, load IDLE; state IDLE.
- o_cmd_ready is high only in IDLE (one command in flight).
- o_wr_rd = adv & write & a NONSEQ/SEQ beat being loaded this cycle (combinational). o_hwdata <= i_wr_data on the same edge. Exactly one o_wr_rd per write beat.
- Grant loss: if i_hready & !i_hgrant while o_htrans==SEQ, rewrite o_htrans to NONSEQ and o_hburst to INCR; address and data unchanged. BUSY is left as is. Remaining beats continue as a new INCR burst. o_hbusreq stays high.
- i_hready low: everything holds, including the counter; o_wr_rd=0.
- Address increment is a 32-bit wrap-around add. Commands past 0xFFFFFFFF are a user error; wrap is not flagged.
- Remaining count is 9 bits; never underflows (LAST entered at 1).

Test Plan:
- Read, addr 0x100, len 0, hready/hgrant=1 -> one beat NONSEQ/SINGLE, hwrite=0, haddr 0x100; busreq high 1 cycle; IDLE next; cmd_ready back 2 cycles after beat.
- Write, addr 0x200, len 3, dav=1 -> NONSEQ,SEQ,SEQ,SEQ at 0x200/204/208/20C, INCR; hwdata D0..D3; 4 o_wr_rd pulses; busreq drops with beat 3.
- Read, addr 0x3F8, len 3 -> 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
- Write, len 2, dav low 2 cycles after beat 0 -> NONSEQ, BUSY(0x204), BUSY(0x204), SEQ(0x204), SEQ(0x208); o_wr_rd only on data beats. Separately, hready low 3 cycles mid-burst -> all outputs frozen.
- Grant drop while SEQ 0x208 presented -> htrans becomes NONSEQ, hburst INCR; on regrant burst resumes 0x208 NONSEQ, 0x20C SEQ.
- Assert i_hreset_n low mid-burst -> outputs immediately at reset values; cmd_ready=1 after release; new command runs normally.
